// File: rtl/sram_1rw_arbiter.sv
// sram_1rw_arbiter
//
// Shares one single-port (1RW) SRAM between two requesters. After reset the
// whole array is zero-filled (INIT). Then one access per cycle is granted
// with round-robin fairness (RUN). Read data comes back with a fixed
// one-cycle latency and is tagged to the requester that issued it.
//
// Ports
//   clock, reset              sole clock; synchronous active-high reset
//   init_done                 high from the first RUN cycle until next reset
//   dbg_state                 current FSM state (0 = INIT, 1 = RUN)
//   reqN_valid/ready          request handshake, N = 0,1
//   reqN_write/addr/wdata     request payload (write = 1, read = 0)
//   respN_valid               read response strobe for requester N
//   resp_rdata                shared read data, qualified by respN_valid
//   RW0_addr/wdata/en/wmode   SRAM command (active-high enables)
//   RW0_rdata                 SRAM read data, valid one cycle after a read
//
// Handshake: a request transfers in any cycle where reqN_valid and
// reqN_ready are both high. Ready is combinational from both valids, so a
// requester must not derive valid from ready. Responses have no
// backpressure; respN_valid is a one-cycle strobe.

module sram_1rw_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 256
) (
    input  logic              clock,
    input  logic              reset,
    output logic              init_done,
    output logic              dbg_state,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              resp0_valid,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0] RW0_addr,
    output logic [DATA_W-1:0] RW0_wdata,
    input  logic [DATA_W-1:0] RW0_rdata,
    output logic              RW0_en,
    output logic              RW0_wmode
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_ptr;       // requester preferred under contention
    logic              r_rd_pend;
    logic              r_rd_id;
    logic              r_init_done;

    logic w_run;
    logic w_both;
    logic w_gnt0;
    logic w_gnt1;
    logic w_gnt_write;

    // Grants are suppressed in the reset cycle so nothing reaches the SRAM
    // while the block is being reset.
    always_comb begin
        w_run       = (r_state == ST_RUN) && !reset;
        w_both      = req0_valid && req1_valid;
        w_gnt0      = w_run && req0_valid && (!req1_valid || (r_ptr == 1'b0));
        w_gnt1      = w_run && req1_valid && (!req0_valid || (r_ptr == 1'b1));
        w_gnt_write = w_gnt0 ? req0_write : req1_write;
    end

    always_comb begin
        RW0_en    = 1'b0;
        RW0_wmode = 1'b0;
        RW0_addr  = '0;
        RW0_wdata = '0;
        if (!reset && (r_state == ST_INIT)) begin
            RW0_en    = 1'b1;
            RW0_wmode = 1'b1;
            RW0_addr  = r_cnt;
        end else if (w_gnt0) begin
            RW0_en    = 1'b1;
            RW0_wmode = req0_write;
            RW0_addr  = req0_addr;
            RW0_wdata = req0_wdata;
        end else if (w_gnt1) begin
            RW0_en    = 1'b1;
            RW0_wmode = req1_write;
            RW0_addr  = req1_addr;
            RW0_wdata = req1_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_INIT;
            r_cnt       <= '0;
            r_ptr       <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_rd_id     <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_rd_pend <= 1'b0;
                    r_cnt     <= r_cnt + ADDR_W'(1);
                    if (r_cnt == LAST_ADDR) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                        r_cnt       <= '0;
                    end
                end
                ST_RUN: begin
                    // Only contention moves the pointer: it goes to the loser.
                    if (w_both) begin
                        r_ptr <= w_gnt0;
                    end
                    r_rd_pend <= (w_gnt0 || w_gnt1) && !w_gnt_write;
                    r_rd_id   <= w_gnt1;
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign init_done   = r_init_done;
    assign dbg_state   = r_state;
    assign req0_ready  = w_gnt0;
    assign req1_ready  = w_gnt1;
    assign resp0_valid = r_rd_pend && (r_rd_id == 1'b0);
    assign resp1_valid = r_rd_pend && (r_rd_id == 1'b1);
    assign resp_rdata  = RW0_rdata;

endmodule
